// File: rtl/pwm_decode.sv
// PWM decoder: measures period and high time of pwm_in, reports duty as floor(H*256/P) via a
// 9-step restoring divider. Define PWM_DECODE_SYNC_EN for a two-flop synchroniser on pwm_in.
module pwm_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [7:0]  duty,
  output logic [15:0] period,
  output logic        valid,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, MEASURE, DIV} state_t;

  state_t      state_q, state_d;
  logic        s_q, s_dly_q, rise_q, rise_d;
  logic [15:0] per_q, per_d, hi_q, hi_d;
  logic [15:0] p_q, p_d, h_q, h_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] period_q, period_d;
  logic        valid_q, valid_d, timeout_q, timeout_d;

  logic [16:0] trial, diff;
  logic        q_bit;
  logic [8:0]  quo_next;

`ifdef PWM_DECODE_SYNC_EN
  logic meta_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      meta_q <= pwm_in;
      s_q    <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 1'b0;
    else     s_q <= pwm_in;
  end
`endif

  always_comb rise_d = s_q & ~s_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_dly_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s_dly_q <= s_q;
      rise_q  <= rise_d;
    end
  end

  // First step compares H itself (quotient bit 8); the remaining eight shift first.
  always_comb begin
    trial    = (cnt_q == 4'd0) ? {1'b0, rem_q} : {rem_q, 1'b0};
    diff     = trial - {1'b0, p_q};
    q_bit    = ~diff[16];
    quo_next = {quo_q, q_bit};
  end

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    p_d       = p_q;
    h_d       = h_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        per_d = 16'd0;
        hi_d  = 16'd0;
        if (rise_q) begin
          state_d = MEASURE;
          per_d   = 16'd1;
          hi_d    = 16'd1;
        end
      end
      MEASURE, DIV: begin
        // s_dly_q lines up with rise_q, so hi_cnt covers exactly the high cycles of the period
        per_d = per_q + 16'd1;
        hi_d  = hi_q + {15'd0, s_dly_q};
        if (rise_q) begin
          p_d     = per_q;
          h_d     = hi_q;
          rem_d   = hi_q;
          quo_d   = 8'd0;
          cnt_d   = 4'd0;
          per_d   = 16'd1;
          hi_d    = 16'd1;
          state_d = DIV;
        end else if (state_q == MEASURE && per_q == 16'hFFFF) begin
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          period_d  = 16'hFFFF;
          duty_d    = s_q ? 8'hFF : 8'h00;
          per_d     = 16'd0;
          hi_d      = 16'd0;
          state_d   = IDLE;
        end else if (state_q == DIV) begin
          rem_d = q_bit ? diff[15:0] : trial[15:0];
          quo_d = quo_next[7:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            period_d  = p_q;
            duty_d    = quo_next[8] ? 8'hFF : quo_next[7:0];
            state_d   = MEASURE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      per_q     <= 16'd0;
      hi_q      <= 16'd0;
      p_q       <= 16'd0;
      h_q       <= 16'd0;
      rem_q     <= 16'd0;
      quo_q     <= 8'd0;
      cnt_q     <= 4'd0;
      duty_q    <= 8'd0;
      period_q  <= 16'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      p_q       <= p_d;
      h_q       <= h_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign duty    = duty_q;
  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pwm_decode.sv
// Bench for pwm_decode: a cycle-level model of rise/DIV timing feeds a scoreboard queue,
// table vectors check steady patterns, hand sequences cover timeout and reset mid-DIV.
module tb_pwm_decode;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [7:0]  duty;
  logic [15:0] period;
  logic        valid, timeout;

  pwm_decode dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty(duty), .period(period), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

`ifdef PWM_DECODE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [7:0]  duty;
    logic [15:0] period;
    logic        timeout;
    int          cyc;
  } exp_t;

  typedef struct {
    int          hi;
    int          lo;
    int          n;
    logic [7:0]  duty;
    logic [15:0] period;
    int          cnt;
  } vec_t;

  exp_t sb[$];
  exp_t e_m, pend, t;
  vec_t vec[9];

  int checks = 0, errors = 0, cyc = 0, nvalid = 0;
  logic [7:0]  last_duty = 8'd0, act_duty = 8'd0;
  logic [15:0] last_period = 16'd0, act_period = 16'd0;
  logic        last_to = 1'b0;

  // stimulus model state
  int   armed = 0, pend_v = 0, pend_d = 0, last_d = 0, hi_acc = 0;
  logic pwm_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dmodel(input int h, input int p);
    int q;
    q = (h * 256) / p;
    return (q > 255) ? 8'hFF : q[7:0];
  endfunction

  task automatic fail_msg(input string s);
    errors++;
    if (errors <= 30) $display("FAIL %s", s);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (valid !== 1'b0 || duty !== 8'd0 || period !== 16'd0 || timeout !== 1'b0)
        fail_msg($sformatf("reset_outputs cyc %0d: valid=%0b duty=%0d period=%0d timeout=%0b, want all 0",
                           cyc, valid, duty, period, timeout));
      last_duty = 8'd0; last_period = 16'd0; last_to = 1'b0;
    end else if (valid) begin
      nvalid++;
      checks++;
      act_duty = duty; act_period = period;
      if (sb.size() == 0) begin
        fail_msg($sformatf("unexpected_valid cyc %0d: duty=%0d period=%0d timeout=%0b, want no valid",
                           cyc, duty, period, timeout));
        last_duty = duty; last_period = period; last_to = timeout;
      end else begin
        e_m = sb.pop_front();
        if (duty !== e_m.duty || period !== e_m.period || timeout !== e_m.timeout || cyc != e_m.cyc)
          fail_msg($sformatf("result: got duty=%0d period=%0d timeout=%0b cyc=%0d, want duty=%0d period=%0d timeout=%0b cyc=%0d",
                             duty, period, timeout, cyc, e_m.duty, e_m.period, e_m.timeout, e_m.cyc));
        last_duty = e_m.duty; last_period = e_m.period; last_to = e_m.timeout;
      end
    end else begin
      checks++;
      if (duty !== last_duty || period !== last_period || timeout !== last_to)
        fail_msg($sformatf("hold cyc %0d: duty=%0d period=%0d timeout=%0b, want duty=%0d period=%0d timeout=%0b",
                           cyc, duty, period, timeout, last_duty, last_period, last_to));
    end
  end

  // One clk of stimulus; a rise yields a result only if no further rise follows within 10 cycles.
  task automatic step(input logic b);
    if (pend_v != 0 && cyc - pend_d >= 10) begin
      sb.push_back(pend);
      pend_v = 0;
    end
    if (b && !pwm_prev) begin
      pend_v = 0;
      if (armed != 0) begin
        pend_v         = 1;
        pend_d         = cyc;
        pend.period    = 16'(cyc - last_d);
        pend.duty      = dmodel(hi_acc, cyc - last_d);
        pend.timeout   = 1'b0;
        pend.cyc       = cyc + LAT + 10;
      end
      armed  = 1;
      last_d = cyc;
      hi_acc = 0;
    end
    if (b) hi_acc++;
    pwm_in   = b;
    pwm_prev = b;
    @(posedge clk); #1;
  endtask

  task automatic pulses(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0);
  endtask

  task automatic do_reset();
    checks++;
    if (sb.size() != 0)
      fail_msg($sformatf("missing_valid: %0d expected results never seen, want 0", sb.size()));
    sb.delete();
    pwm_in = 1'b0; pwm_prev = 1'b0;
    armed = 0; pend_v = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n0;
    vec[0] = '{64, 192, 4, 8'd64,  16'd256, 3};
    vec[1] = '{10, 10,  4, 8'd128, 16'd20,  3};
    vec[2] = '{7,  3,   4, 8'd179, 16'd10,  3};
    vec[3] = '{1,  9,   4, 8'd25,  16'd10,  3};
    vec[4] = '{5,  4,   4, 8'd142, 16'd9,   1};
    vec[5] = '{3,  3,   5, 8'd128, 16'd6,   1};
    vec[6] = '{30, 70,  3, 8'd76,  16'd100, 2};
    vec[7] = '{200, 56, 3, 8'd200, 16'd256, 2};
    vec[8] = '{1,  1,   6, 8'd128, 16'd2,   1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_reset();
      n0 = nvalid;
      pulses(vec[i].hi, vec[i].lo, vec[i].n);
      idle(25);
      checks++;
      if (nvalid - n0 != vec[i].cnt || act_duty !== vec[i].duty || act_period !== vec[i].period)
        fail_msg($sformatf("vec%0d %0d/%0d: got %0d valids duty=%0d period=%0d, want %0d valids duty=%0d period=%0d",
                           i, vec[i].hi, vec[i].lo, nvalid - n0, act_duty, act_period,
                           vec[i].cnt, vec[i].duty, vec[i].period));
    end

    // long-high then single-cycle pulses
    do_reset();
    pulses(255, 1, 3);
    pulses(1, 99, 3);
    idle(20);
    checks++;
    if (act_duty !== 8'd2 || act_period !== 16'd100)
      fail_msg($sformatf("mixed_pattern: duty=%0d period=%0d, want duty=2 period=100", act_duty, act_period));

    // short periods suppress results until the line slows down
    do_reset();
    n0 = nvalid;
    pulses(3, 3, 5);
    checks++;
    if (nvalid != n0)
      fail_msg($sformatf("short_period: %0d valids during 6-cycle pattern, want 0", nvalid - n0));
    pulses(10, 10, 3);
    idle(25);
    checks++;
    if (act_duty !== 8'd128 || act_period !== 16'd20)
      fail_msg($sformatf("after_short: duty=%0d period=%0d, want duty=128 period=20", act_duty, act_period));

    // reset asserted mid-division, held until the line is low again
    do_reset();
    pulses(64, 192, 1);
    repeat (5) step(1'b1);
    #2 rst = 1'b1;
    armed = 0; pend_v = 0;
    #1;
    checks++;
    if (valid !== 1'b0 || duty !== 8'd0 || period !== 16'd0 || timeout !== 1'b0)
      fail_msg($sformatf("async_reset: valid=%0b duty=%0d period=%0d timeout=%0b, want all 0",
                         valid, duty, period, timeout));
    @(posedge clk); #1;
    repeat (58) step(1'b1);
    repeat (20) step(1'b0);
    rst = 1'b0;
    idle(172);
    n0 = nvalid;
    pulses(64, 192, 3);
    idle(20);
    checks++;
    if (nvalid - n0 != 2 || act_duty !== 8'd64 || act_period !== 16'd256)
      fail_msg($sformatf("post_reset: %0d valids duty=%0d period=%0d, want 2 valids duty=64 period=256",
                         nvalid - n0, act_duty, act_period));

    // stuck-high line times out, next rise only re-arms
    do_reset();
    idle(5);
    t.duty = 8'hFF; t.period = 16'hFFFF; t.timeout = 1'b1; t.cyc = cyc + LAT + 65536;
    sb.push_back(t);
    repeat (65545) step(1'b1);
    armed = 0;
    checks++;
    if (sb.size() != 0 || act_duty !== 8'hFF || act_period !== 16'hFFFF)
      fail_msg($sformatf("timeout: pending=%0d duty=%0d period=%0d, want 0 pending duty=255 period=65535",
                         sb.size(), act_duty, act_period));
    idle(10);
    n0 = nvalid;
    pulses(64, 192, 3);
    idle(20);
    checks++;
    if (nvalid - n0 != 2 || act_duty !== 8'd64)
      fail_msg($sformatf("after_timeout: %0d valids duty=%0d, want 2 valids duty=64", nvalid - n0, act_duty));

    checks++;
    if (sb.size() != 0)
      fail_msg($sformatf("missing_valid_end: %0d expected results never seen, want 0", sb.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
